// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: N-bank frame buffer, commit/release handshake.
// Option PINGPONG_DROP_EN: drop overflowing frames instead of stalling.
module pingpong_bank_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 8,
  parameter  int NBANKS = 2,
  localparam int BW     = $clog2(NBANKS)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     rd_avail,
  output logic [ADDR_W:0]          rd_len,
  input  logic                     rd_en,
  input  logic                     rd_done,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [BW:0]              frames,
  output logic [7:0]               drop_cnt,
  output logic [NBANKS-1:0]        ram_we,
  output logic [ADDR_W-1:0]        ram_waddr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic [NBANKS-1:0]        ram_re,
  output logic [ADDR_W-1:0]        ram_raddr,
  input  logic [NBANKS*DATA_W-1:0] ram_rdata
);

  localparam logic [BW:0]   NB_C   = (BW+1)'(NBANKS);
  localparam logic [BW-1:0] RB_MAX = BW'(NBANKS-1);

  logic [BW-1:0] rb_q, rb_d;
  logic [BW:0]   cnt_q, cnt_d;
  logic [ADDR_W:0] wa_q, wa_d;
  logic [ADDR_W:0] ra_q, ra_d;
  logic [ADDR_W:0] len_q [NBANKS];
  logic [ADDR_W:0] len_d [NBANKS];
  logic [BW-1:0] rsel_q, rsel_d;
  logic          rvld_q, rvld_d;

  logic [BW:0]     wb_sum;
  logic [BW-1:0]   wb;
  logic [ADDR_W:0] wlen;
  logic acc, wr_do, commit, drop, keep;
  logic rd_go, rel;

  // Handshake decode, write bank selection and next-state computation
  always_comb begin
    wb_sum = {1'b0, rb_q} + cnt_q;
    if (wb_sum >= NB_C) wb_sum = wb_sum - NB_C;
    wb = wb_sum[BW-1:0];

`ifdef PINGPONG_DROP_EN
    wr_ready = 1'b1;
`else
    wr_ready = (cnt_q != NB_C);
`endif
    rd_avail = (cnt_q != '0);
    rd_len   = len_q[rb_q];
    frames   = cnt_q;

    acc    = wr_valid & wr_ready;
    wr_do  = acc & ~wa_q[ADDR_W];
    commit = acc & wr_last;
`ifdef PINGPONG_DROP_EN
    drop   = commit & (cnt_q == NB_C - 1'b1);
`else
    drop   = 1'b0;
`endif
    keep   = commit & ~drop;
    rd_go  = rd_en & rd_avail & (ra_q < len_q[rb_q]);
    rel    = rd_done & rd_avail;

    for (int b = 0; b < NBANKS; b++) begin
      ram_we[b] = wr_do & (wb == BW'(b));
      ram_re[b] = rd_go & (rb_q == BW'(b));
    end
    ram_waddr = wr_do ? wa_q[ADDR_W-1:0] : '0;
    ram_wdata = wr_do ? wr_data : '0;
    ram_raddr = rd_go ? ra_q[ADDR_W-1:0] : '0;

    wlen = wr_do ? wa_q + 1'b1 : wa_q;

    wa_d = wa_q;
    if (wr_do) wa_d = wa_q + 1'b1;
    if (commit) wa_d = '0;

    len_d = len_q;
    if (keep) len_d[wb] = wlen;

    cnt_d = cnt_q;
    unique case ({keep, rel})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    rb_d = rb_q;
    if (rel) rb_d = (rb_q == RB_MAX) ? '0 : rb_q + 1'b1;

    ra_d = ra_q;
    if (rd_go) ra_d = ra_q + 1'b1;
    if (rel) ra_d = '0;

    rsel_d = rd_go ? rb_q : rsel_q;
    rvld_d = rd_go;
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rb_q   <= '0;
      cnt_q  <= '0;
      wa_q   <= '0;
      ra_q   <= '0;
      rsel_q <= '0;
      rvld_q <= 1'b0;
      for (int b = 0; b < NBANKS; b++) len_q[b] <= '0;
    end else begin
      rb_q   <= rb_d;
      cnt_q  <= cnt_d;
      wa_q   <= wa_d;
      ra_q   <= ra_d;
      rsel_q <= rsel_d;
      rvld_q <= rvld_d;
      len_q  <= len_d;
    end
  end

  // Read data steered from the bank latched with the request
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NBANKS; b++)
      if (rvld_q && rsel_q == BW'(b))
        rd_data = ram_rdata[b*DATA_W +: DATA_W];
  end

  assign rd_valid = rvld_q;

`ifdef PINGPONG_DROP_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of discarded frames
  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 8'hff) drop_d = drop_q + 1'b1;
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (!resetn) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// tb_pingpong_bank_ctrl: frame-queue reference model, random traffic.
// Covers default build and PINGPONG_DROP_EN builds.
module tb_pingpong_bank_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NB = 2;
  localparam int BW = $clog2(NB);
  localparam int DEPTH = 1 << AW;
`ifdef PINGPONG_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic wr_valid, wr_last, wr_ready;
  logic [DW-1:0] wr_data;
  logic rd_avail, rd_en, rd_done, rd_valid;
  logic [AW:0] rd_len;
  logic [DW-1:0] rd_data;
  logic [BW:0] frames;
  logic [7:0] drop_cnt;
  logic [NB-1:0] ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [NB*DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  pingpong_bank_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .NBANKS(NB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_avail(rd_avail), .rd_len(rd_len),
    .rd_en(rd_en), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frames(frames), .drop_cnt(drop_cnt),
    .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_re(ram_re),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // external synchronous RAMs
  logic [DW-1:0] mem [NB][DEPTH];
  logic [DW-1:0] rq [NB];

  always @(posedge clk)
    for (int b = 0; b < NB; b++) begin
      if (ram_we[b]) mem[b][ram_waddr] <= ram_wdata;
      if (ram_re[b]) rq[b] <= mem[b][ram_raddr];
    end

  always_comb begin
    ram_rdata = '0;
    for (int b = 0; b < NB; b++)
      ram_rdata[b*DW +: DW] = rq[b];
  end

  // reference model: committed words in order, frame lengths
  logic [DW-1:0] words [$];
  int lens [$];
  logic [DW-1:0] part [$];
  int rptr, hb, drops;
  bit exp_rv;
  logic [DW-1:0] exp_rd;

  int n_chk, n_bad;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    words.delete();
    lens.delete();
    part.delete();
    rptr = 0;
    hb = 0;
    drops = 0;
    exp_rv = 0;
    exp_rd = '0;
  endfunction

  function automatic bit m_ready();
    return DROP ? 1'b1 : (lens.size() != NB);
  endfunction

  // compare outputs against the model at mid-cycle
  task automatic check_outs();
    int nfr;
    bit acc, wdo, rok;
    int wbk;
    nfr = lens.size();
    acc = wr_valid && m_ready();
    wdo = acc && part.size() < DEPTH;
    wbk = (hb + nfr) % NB;
    rok = rd_en && nfr != 0 && rptr < lens[0];
    check("wr_ready", wr_ready, m_ready());
    check("rd_avail", rd_avail, nfr != 0);
    check("frames", frames, nfr);
    check("drop_cnt", drop_cnt, drops);
    if (nfr != 0) check("rd_len", rd_len, lens[0]);
    check("ram_we", ram_we, wdo ? (1 << wbk) : 0);
    check("ram_wdata", ram_wdata, wdo ? wr_data : 0);
    if (wdo) check("ram_waddr", ram_waddr, part.size());
    check("ram_re", ram_re, rok ? (1 << hb) : 0);
    if (rok) check("ram_raddr", ram_raddr, rptr);
    check("rd_valid", rd_valid, exp_rv);
    if (exp_rv) check("rd_data", rd_data, exp_rd);
  endtask

  // advance the model by one clock edge
  function automatic void model_step();
    int nfr;
    bit acc, rok, rel, cmt, drp;
    nfr = lens.size();
    acc = wr_valid && m_ready();
    rok = rd_en && nfr != 0 && rptr < lens[0];
    rel = rd_done && nfr != 0;
    cmt = acc && wr_last;
    drp = cmt && DROP && nfr == NB - 1;
    exp_rv = rok;
    if (rok) begin
      exp_rd = words[rptr];
      rptr++;
    end
    if (acc && part.size() < DEPTH) part.push_back(wr_data);
    if (rel) begin
      for (int i = 0; i < lens[0]; i++) void'(words.pop_front());
      void'(lens.pop_front());
      rptr = 0;
      hb = (hb + 1) % NB;
    end
    if (cmt) begin
      if (drp) begin
        if (drops < 255) drops++;
      end else begin
        foreach (part[i]) words.push_back(part[i]);
        lens.push_back(part.size());
      end
      part.delete();
    end
  endfunction

  task automatic cyc(input bit v, input logic [DW-1:0] d,
                     input bit l, input bit re, input bit dn);
    wr_valid = v;
    wr_data  = d;
    wr_last  = l;
    rd_en    = re;
    rd_done  = dn;
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wr_valid = 0; wr_data = '0; wr_last = 0;
    rd_en = 0; rd_done = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    model_clear();
    do_reset();
    do_reset();

    @(negedge clk);
    check("rst_frames", frames, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_avail", rd_avail, 0);
    check("rst_len", rd_len, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_rvalid", rd_valid, 0);
    check("rst_rdata", rd_data, 0);
    @(posedge clk);
    #1;

    // one full-depth frame, read back
    for (int i = 0; i < 4; i++)
      cyc(1, 8'h11 + 8'(i), i == 3, 0, 0);
    idle(1);
    check("t1_len", rd_len, 4);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, 0);
    idle(1);
    cyc(0, '0, 0, 0, 1);
    idle(1);

    // two frames fill both banks
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 3; i++)
        cyc(1, 8'(8'h20 + 8'(f*4 + i)), i == 2, 0, 0);
    idle(1);
    check("t2_ready", wr_ready, DROP ? 1 : 0);
    cyc(0, '0, 0, 0, 1);
    idle(1);
    cyc(1, 8'h5a, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1);
    idle(1);

    // commit and release in the same cycle
    do_reset();
    cyc(1, 8'h31, 0, 0, 0);
    cyc(1, 8'h32, 1, 0, 0);
    cyc(1, 8'h41, 0, 1, 0);
    cyc(1, 8'h42, 1, 1, 1);
    idle(1);
    check("t3_frames", frames, 1);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1);
    idle(1);

    // oversize frame saturates at depth
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1, 8'h60 + 8'(i), i == 5, 0, 0);
    idle(1);
    check("t4_len", rd_len, 4);
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 1, 0);
    idle(1);
    check("t4_rvalid", rd_valid, 0);
    cyc(0, '0, 0, 0, 1);

    // reset mid-frame
    cyc(1, 8'h71, 0, 0, 0);
    cyc(1, 8'h72, 0, 0, 0);
    do_reset();
    @(negedge clk);
    check("t5_frames", frames, 0);
    check("t5_ready", wr_ready, 1);
    check("t5_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    cyc(1, 8'h73, 1, 0, 0);
    idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0,
          DW'($urandom),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
